// File: rtl/memtrace_lane_serializer_if.sv
// Trace-beat input, single-lane memory request and load-response signals of the lane serializer.
// The master modport is the serializer; the slave modport is the trace source and memory side.
interface memtrace_lane_serializer_if #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 8
);
  localparam int TAG_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                             trace_read_ready;
  logic [NUM_LANES-1:0]             trace_read_valid;
  logic [DATA_WIDTH*NUM_LANES-1:0]  trace_read_address;
  logic [NUM_LANES-1:0]             trace_read_is_store;
  logic [MASK_WIDTH*NUM_LANES-1:0]  trace_read_store_mask;
  logic [DATA_WIDTH*NUM_LANES-1:0]  trace_read_data;
  logic                             trace_read_finished;

  logic                             req_valid;
  logic                             req_ready;
  logic [DATA_WIDTH-1:0]            req_address;
  logic                             req_is_store;
  logic [MASK_WIDTH-1:0]            req_store_mask;
  logic [DATA_WIDTH-1:0]            req_data;
  logic [TAG_W-1:0]                 req_tag;

  logic                             resp_valid;

  modport master (
    output trace_read_ready,
    input  trace_read_valid, trace_read_address, trace_read_is_store,
    input  trace_read_store_mask, trace_read_data, trace_read_finished,
    output req_valid, req_address, req_is_store, req_store_mask, req_data, req_tag,
    input  req_ready, resp_valid
  );

  modport slave (
    input  trace_read_ready,
    output trace_read_valid, trace_read_address, trace_read_is_store,
    output trace_read_store_mask, trace_read_data, trace_read_finished,
    input  req_valid, req_address, req_is_store, req_store_mask, req_data, req_tag,
    output req_ready, resp_valid
  );
endinterface

// File: rtl/memtrace_lane_serializer.sv
// Captures a multi-lane memory trace beat and issues its valid lanes one per cycle as
// single-lane requests, tracking outstanding loads and signalling when the trace has drained.
module memtrace_lane_serializer #(
  parameter int NUM_LANES    = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int MASK_WIDTH   = 8,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  memtrace_lane_serializer_if.master  bus,
  output logic [7:0]                  inflight_count,
  output logic                        done,
  output logic                        resp_error
);
  localparam int TAG_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t                           r_state;
  logic [NUM_LANES-1:0]             r_pend;
  logic [NUM_LANES-1:0]             r_store;
  logic [DATA_WIDTH*NUM_LANES-1:0]  r_addr;
  logic [DATA_WIDTH*NUM_LANES-1:0]  r_data;
  logic [MASK_WIDTH*NUM_LANES-1:0]  r_mask;
  logic                             r_fin;
  logic                             r_err;
  logic [7:0]                       r_inflight;

  logic [NUM_LANES-1:0]   w_sel_oh;
  logic [TAG_W-1:0]       w_sel;
  logic [DATA_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [MASK_WIDTH-1:0]  w_mask;
  logic                   w_store;
  logic                   w_fin;
  logic                   w_full;
  logic                   w_req_valid;
  logic                   w_fire;
  logic                   w_load_acc;
  logic [NUM_LANES-1:0]   w_pend_next;

  // Lowest-indexed pending lane wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    w_sel_oh = '0;
    w_sel    = '0;
    w_addr   = '0;
    w_data   = '0;
    w_mask   = '0;
    w_store  = 1'b0;
    for (int g = NUM_LANES - 1; g >= 0; g--) begin
      if (r_pend[g]) begin
        w_sel_oh    = '0;
        w_sel_oh[g] = 1'b1;
        w_sel       = TAG_W'(g);
        w_addr      = r_addr[g*DATA_WIDTH +: DATA_WIDTH];
        w_data      = r_data[g*DATA_WIDTH +: DATA_WIDTH];
        w_mask      = r_mask[g*MASK_WIDTH +: MASK_WIDTH];
        w_store     = r_store[g];
      end
    end
  end

  assign w_fin       = r_fin | bus.trace_read_finished;
  assign w_full      = (r_inflight == 8'(MAX_INFLIGHT));
  // A response arriving this cycle frees a slot, so a load may issue into a full window.
  assign w_req_valid = !reset && (r_state == SEND) && (|r_pend) &&
                       !(!w_store && w_full && !bus.resp_valid);
  assign w_fire      = w_req_valid && bus.req_ready;
  assign w_load_acc  = w_fire && !w_store;
  assign w_pend_next = r_pend & ~w_sel_oh;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_store    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_fin      <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= '0;
    end else begin
      r_fin <= w_fin;
      if (w_load_acc && !bus.resp_valid) begin
        r_inflight <= r_inflight + 8'd1;
      end else if (!w_load_acc && bus.resp_valid) begin
        if (r_inflight == 8'd0) r_err <= 1'b1;
        else                    r_inflight <= r_inflight - 8'd1;
      end
      case (r_state)
        IDLE: begin
          if (|bus.trace_read_valid) begin
            r_pend  <= bus.trace_read_valid;
            r_store <= bus.trace_read_is_store;
            r_addr  <= bus.trace_read_address;
            r_data  <= bus.trace_read_data;
            r_mask  <= bus.trace_read_store_mask;
            r_state <= SEND;
          end else if (w_fin) begin
            r_state <= DRAIN;
          end
        end
        SEND: begin
          if (w_fire) begin
            r_pend <= w_pend_next;
            if (w_pend_next == '0) r_state <= w_fin ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (r_inflight == 8'd0) r_state <= DONE;
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.trace_read_ready = (r_state == IDLE) && !reset;
  assign bus.req_valid        = w_req_valid;
  assign bus.req_address      = reset ? '0 : w_addr;
  assign bus.req_is_store     = reset ? 1'b0 : w_store;
  assign bus.req_store_mask   = reset ? '0 : w_mask;
  assign bus.req_data         = reset ? '0 : w_data;
  assign bus.req_tag          = reset ? '0 : w_sel;
  assign inflight_count       = reset ? 8'd0 : r_inflight;
  assign done                 = (r_state == DONE) && !reset;
  assign resp_error           = r_err && !reset;
endmodule

// File: tb/tb_memtrace_lane_serializer.sv
// Directed bench for memtrace_lane_serializer: four lanes, 16-bit data, two-load window.
module tb_memtrace_lane_serializer;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int MW = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] inflight_count;
  logic       done;
  logic       resp_error;
  int         n_vec = 0;
  int         n_err = 0;

  memtrace_lane_serializer_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  memtrace_lane_serializer #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .MAX_INFLIGHT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .inflight_count(inflight_count),
    .done(done),
    .resp_error(resp_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane g: address 0x1000+g, data 0x00D0+g, mask 0x10+g.
  task automatic beat(input logic [3:0] v, input logic [3:0] st);
    bus.trace_read_valid    = v;
    bus.trace_read_is_store = st;
    for (int g = 0; g < NL; g++) begin
      bus.trace_read_address[g*DW +: DW]    = 16'h1000 + 16'(g);
      bus.trace_read_data[g*DW +: DW]       = 16'h00D0 + 16'(g);
      bus.trace_read_store_mask[g*MW +: MW] = 8'h10 + 8'(g);
    end
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.trace_read_valid      = '0;
    bus.trace_read_address    = '0;
    bus.trace_read_is_store   = '0;
    bus.trace_read_store_mask = '0;
    bus.trace_read_data       = '0;
    bus.trace_read_finished   = 1'b0;
    bus.req_ready             = 1'b0;
    bus.resp_valid            = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.trace_read_ready), 32'd0);
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(resp_error), 32'd0);
    chk("rst_count", 32'(inflight_count), 32'd0);
    chk("rst_req_addr", 32'(bus.req_address), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.trace_read_ready), 32'd1);

    // Mixed beat: loads on lanes 0/1, store on lane 3.
    bus.req_ready = 1'b1;
    beat(4'b1011, 4'b1000);
    step();
    bus.trace_read_valid = '0;
    #1;
    chk("A_ready_c1", 32'(bus.trace_read_ready), 32'd0);
    chk("A_valid_c1", 32'(bus.req_valid), 32'd1);
    chk("A_tag_c1", 32'(bus.req_tag), 32'd0);
    chk("A_addr_c1", 32'(bus.req_address), 32'h1000);
    chk("A_store_c1", 32'(bus.req_is_store), 32'd0);
    step();
    chk("A_tag_c2", 32'(bus.req_tag), 32'd1);
    chk("A_cnt_c2", 32'(inflight_count), 32'd1);
    chk("A_ready_c2", 32'(bus.trace_read_ready), 32'd0);
    step();
    chk("A_tag_c3", 32'(bus.req_tag), 32'd3);
    chk("A_store_c3", 32'(bus.req_is_store), 32'd1);
    chk("A_mask_c3", 32'(bus.req_store_mask), 32'h13);
    chk("A_data_c3", 32'(bus.req_data), 32'h00D3);
    chk("A_cnt_c3", 32'(inflight_count), 32'd2);
    chk("A_ready_c3", 32'(bus.trace_read_ready), 32'd0);
    step();
    chk("A_ready_c4", 32'(bus.trace_read_ready), 32'd1);
    chk("A_valid_c4", 32'(bus.req_valid), 32'd0);
    chk("A_cnt_c4", 32'(inflight_count), 32'd2);
    rst_pulse();
    chk("A_cnt_after_rst", 32'(inflight_count), 32'd0);

    // Backpressure on lane 0.
    bus.req_ready = 1'b0;
    beat(4'b0011, 4'b0000);
    step();
    bus.trace_read_valid = '0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("B_stall_valid", 32'(bus.req_valid), 32'd1);
      chk("B_stall_tag", 32'(bus.req_tag), 32'd0);
      chk("B_stall_addr", 32'(bus.req_address), 32'h1000);
      step();
    end
    bus.req_ready = 1'b1;
    #1;
    chk("B_hs_tag", 32'(bus.req_tag), 32'd0);
    chk("B_hs_valid", 32'(bus.req_valid), 32'd1);
    step();
    chk("B_next_tag", 32'(bus.req_tag), 32'd1);
    chk("B_next_addr", 32'(bus.req_address), 32'h1001);
    chk("B_next_cnt", 32'(inflight_count), 32'd1);
    step();
    chk("B_end_ready", 32'(bus.trace_read_ready), 32'd1);
    chk("B_end_cnt", 32'(inflight_count), 32'd2);
    rst_pulse();

    // Inflight window limit of two loads.
    bus.req_ready = 1'b1;
    beat(4'b0111, 4'b0000);
    step();
    bus.trace_read_valid = '0;
    #1;
    chk("C_tag_c1", 32'(bus.req_tag), 32'd0);
    step();
    chk("C_tag_c2", 32'(bus.req_tag), 32'd1);
    chk("C_cnt_c2", 32'(inflight_count), 32'd1);
    step();
    chk("C_cnt_c3", 32'(inflight_count), 32'd2);
    chk("C_stall_c3", 32'(bus.req_valid), 32'd0);
    chk("C_tag_c3", 32'(bus.req_tag), 32'd2);
    step();
    chk("C_stall_c4", 32'(bus.req_valid), 32'd0);
    bus.resp_valid = 1'b1;
    #1;
    chk("C_resp_valid", 32'(bus.req_valid), 32'd1);
    chk("C_resp_tag", 32'(bus.req_tag), 32'd2);
    step();
    bus.resp_valid = 1'b0;
    #1;
    chk("C_cnt_c5", 32'(inflight_count), 32'd2);
    chk("C_ready_c5", 32'(bus.trace_read_ready), 32'd1);
    chk("C_valid_c5", 32'(bus.req_valid), 32'd0);
    rst_pulse();

    // Finished with the last beat, then drain to done.
    bus.req_ready = 1'b1;
    beat(4'b0001, 4'b0000);
    bus.trace_read_finished = 1'b1;
    step();
    bus.trace_read_valid    = '0;
    bus.trace_read_finished = 1'b0;
    #1;
    chk("D_tag_c1", 32'(bus.req_tag), 32'd0);
    chk("D_valid_c1", 32'(bus.req_valid), 32'd1);
    step();
    chk("D_ready_c2", 32'(bus.trace_read_ready), 32'd0);
    chk("D_done_c2", 32'(done), 32'd0);
    chk("D_cnt_c2", 32'(inflight_count), 32'd1);
    step();
    step();
    bus.resp_valid = 1'b1;
    step();
    bus.resp_valid = 1'b0;
    #1;
    chk("D_cnt_c5", 32'(inflight_count), 32'd0);
    chk("D_done_c5", 32'(done), 32'd0);
    chk("D_ready_c5", 32'(bus.trace_read_ready), 32'd0);
    step();
    chk("D_done_c6", 32'(done), 32'd1);
    chk("D_ready_c6", 32'(bus.trace_read_ready), 32'd0);
    beat(4'b0001, 4'b0000);
    step();
    chk("D_done_c7", 32'(done), 32'd1);
    chk("D_valid_c7", 32'(bus.req_valid), 32'd0);
    chk("D_ready_c7", 32'(bus.trace_read_ready), 32'd0);
    bus.trace_read_valid = '0;
    rst_pulse();
    chk("D_done_after_rst", 32'(done), 32'd0);
    chk("D_ready_after_rst", 32'(bus.trace_read_ready), 32'd1);

    // Spurious response while idle.
    chk("E_err_before", 32'(resp_error), 32'd0);
    bus.resp_valid = 1'b1;
    step();
    bus.resp_valid = 1'b0;
    #1;
    chk("E_err", 32'(resp_error), 32'd1);
    chk("E_cnt", 32'(inflight_count), 32'd0);
    chk("E_ready", 32'(bus.trace_read_ready), 32'd1);
    step();
    chk("E_err_sticky", 32'(resp_error), 32'd1);
    rst_pulse();
    chk("E_err_after_rst", 32'(resp_error), 32'd0);

    // Reset in the middle of SEND with two lanes still pending.
    bus.req_ready = 1'b1;
    beat(4'b0111, 4'b0000);
    step();
    bus.trace_read_valid = '0;
    #1;
    chk("F_tag_c1", 32'(bus.req_tag), 32'd0);
    step();
    chk("F_tag_c2", 32'(bus.req_tag), 32'd1);
    reset = 1'b1;
    #1;
    chk("F_rst_valid", 32'(bus.req_valid), 32'd0);
    chk("F_rst_ready", 32'(bus.trace_read_ready), 32'd0);
    chk("F_rst_cnt", 32'(inflight_count), 32'd0);
    step();
    chk("F_rst_valid_c3", 32'(bus.req_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("F_ready_after", 32'(bus.trace_read_ready), 32'd1);
    chk("F_valid_after", 32'(bus.req_valid), 32'd0);
    chk("F_cnt_after", 32'(inflight_count), 32'd0);
    step();
    chk("F_valid_c4", 32'(bus.req_valid), 32'd0);
    chk("F_ready_c4", 32'(bus.trace_read_ready), 32'd1);
    chk("F_cnt_c4", 32'(inflight_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
